// File: rtl/ssd_pkg.sv
// Shared sizing helpers and default parameters for the SSD disparity stream.
package ssd_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_WIDTH    = 640;
    localparam int unsigned DEF_WIN      = 5;
    localparam int unsigned DEF_DISP_MAX = 16;

    // Exact window sum of WIN squared DATA_W-bit differences.
    function automatic int unsigned cost_w(int unsigned data_w, int unsigned win);
        return 2 * data_w + $clog2(win + 1);
    endfunction

    function automatic int unsigned disp_w(int unsigned disp_max);
        return (disp_max > 1) ? $clog2(disp_max) : 1;
    endfunction

    // Columns below this value lack a full window at the largest disparity.
    function automatic int unsigned border_th(int unsigned win, int unsigned disp_max);
        return win + disp_max - 2;
    endfunction

    typedef logic [DEF_DISP_MAX-1:0][cost_w(DEF_DATA_W, DEF_WIN)-1:0] cost_vec_t;

endpackage

// File: rtl/ssd_argmin.sv
// Linear argmin over N costs; strict compare keeps the lowest index on ties.
module ssd_argmin #(
    parameter int unsigned N      = 16,
    parameter int unsigned COST_W = 19,
    parameter int unsigned DISP_W = 4
) (
    input  logic [N-1:0][COST_W-1:0] i_cost,
    output logic [DISP_W-1:0]        o_disp,
    output logic [COST_W-1:0]        o_cost
);

    // Walk the candidates in order, replacing the best only on a strictly smaller cost.
    always_comb begin
        o_disp = '0;
        o_cost = i_cost[0];
        for (int d = 1; d < N; d++) begin
            if (i_cost[d] < o_cost) begin
                o_cost = i_cost[d];
                o_disp = DISP_W'(d);
            end
        end
    end

endmodule

// File: rtl/ssd_disparity_stream.sv
// Streaming 1-D SSD stereo matcher: history registers, then three pipeline stages
// (squared differences, window sums, argmin), one result per valid input beat.
module ssd_disparity_stream
    import ssd_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned WIN      = DEF_WIN,
    parameter int unsigned DISP_MAX = DEF_DISP_MAX,
    localparam int unsigned COST_W  = cost_w(DATA_W, WIN),
    localparam int unsigned DISP_W  = disp_w(DISP_MAX)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              in_valid,
    input  logic              in_sol,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_l,
    input  logic [DATA_W-1:0] in_r,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_sol,
    output logic              out_eol,
    output logic              out_border,
    output logic [DISP_W-1:0] out_disp,
    output logic [COST_W-1:0] out_cost,
    output logic              line_err
);

    localparam int unsigned RH_N      = WIN + DISP_MAX - 1;
    localparam int unsigned SQ_W      = 2 * DATA_W;
    localparam int unsigned X_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BORDER_TH = border_th(WIN, DISP_MAX);
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);

    // Stage 0: histories (entry 0 is the newest pixel) and the column of that pixel.
    logic [WIN-1:0][DATA_W-1:0]  r_lh;
    logic [RH_N-1:0][DATA_W-1:0] r_rh;
    logic [X_W-1:0]              r_x;
    logic                        r_line_err;
    logic                        r_v0, r_sof0, r_sol0;
    logic                        w_border0, w_eol0;

    // Stage 1..2 data and sideband.
    logic [DISP_MAX-1:0][WIN-1:0][SQ_W-1:0] w_sq, r_sq;
    logic [DISP_MAX-1:0][COST_W-1:0]        w_sum, r_sum;
    logic [DATA_W-1:0]                      w_ad;
    logic r_v1, r_sof1, r_sol1, r_eol1, r_bord1;
    logic r_v2, r_sof2, r_sol2, r_eol2, r_bord2;
    logic [DISP_W-1:0] w_best_disp;
    logic [COST_W-1:0] w_best_cost;

    assign w_border0 = (32'(r_x) < BORDER_TH);
    assign w_eol0    = (r_x == X_LAST);
    assign line_err  = r_line_err;

    // Shift histories on valid beats, track the column and flag over-long lines.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_lh       <= '0;
            r_rh       <= '0;
            r_x        <= '0;
            r_line_err <= 1'b0;
            r_v0       <= 1'b0;
            r_sof0     <= 1'b0;
            r_sol0     <= 1'b0;
        end else begin
            r_v0   <= in_valid;
            r_sof0 <= in_valid & in_sof;
            r_sol0 <= in_valid & (in_sol | in_sof);
            if (in_valid) begin
                for (int i = WIN - 1; i > 0; i--) r_lh[i] <= r_lh[i-1];
                for (int i = RH_N - 1; i > 0; i--) r_rh[i] <= r_rh[i-1];
                r_lh[0] <= in_l;
                r_rh[0] <= in_r;
                if (in_sol | in_sof) begin
                    r_x <= '0;
                end else if (r_x == X_LAST) begin
                    r_line_err <= 1'b1;
                end else begin
                    r_x <= r_x + X_W'(1);
                end
                if (in_sof) r_line_err <= 1'b0;
            end
        end
    end

    // Squared difference per (d,k); |L-R|^2 equals the square of the signed difference.
    always_comb begin
        w_sq = '0;
        w_ad = '0;
        for (int d = 0; d < DISP_MAX; d++) begin
            for (int k = 0; k < WIN; k++) begin
                w_ad = (r_lh[k] >= r_rh[k+d]) ? (r_lh[k] - r_rh[k+d]) : (r_rh[k+d] - r_lh[k]);
                w_sq[d][k] = SQ_W'(w_ad) * SQ_W'(w_ad);
            end
        end
    end

    // Exact window sum per disparity.
    always_comb begin
        w_sum = '0;
        for (int d = 0; d < DISP_MAX; d++) begin
            for (int k = 0; k < WIN; k++) begin
                w_sum[d] = w_sum[d] + COST_W'(r_sq[d][k]);
            end
        end
    end

    // S1 and S2 registers with their sideband flags.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sq    <= '0;
            r_sum   <= '0;
            r_v1    <= 1'b0;
            r_sof1  <= 1'b0;
            r_sol1  <= 1'b0;
            r_eol1  <= 1'b0;
            r_bord1 <= 1'b0;
            r_v2    <= 1'b0;
            r_sof2  <= 1'b0;
            r_sol2  <= 1'b0;
            r_eol2  <= 1'b0;
            r_bord2 <= 1'b0;
        end else begin
            r_sq    <= w_sq;
            r_v1    <= r_v0;
            r_sof1  <= r_sof0;
            r_sol1  <= r_sol0;
            r_eol1  <= r_v0 & w_eol0;
            r_bord1 <= r_v0 & w_border0;
            r_sum   <= w_sum;
            r_v2    <= r_v1;
            r_sof2  <= r_sof1;
            r_sol2  <= r_sol1;
            r_eol2  <= r_eol1;
            r_bord2 <= r_bord1;
        end
    end

    ssd_argmin #(
        .N      (DISP_MAX),
        .COST_W (COST_W),
        .DISP_W (DISP_W)
    ) u_argmin (
        .i_cost (r_sum),
        .o_disp (w_best_disp),
        .o_cost (w_best_cost)
    );

    // S3: register the winner; border and idle beats present zero disparity and cost.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_sol    <= 1'b0;
            out_eol    <= 1'b0;
            out_border <= 1'b0;
            out_disp   <= '0;
            out_cost   <= '0;
        end else begin
            out_valid  <= r_v2;
            out_sof    <= r_sof2;
            out_sol    <= r_sol2;
            out_eol    <= r_eol2;
            out_border <= r_bord2;
            if (r_v2 && !r_bord2) begin
                out_disp <= w_best_disp;
                out_cost <= w_best_cost;
            end else begin
                out_disp <= '0;
                out_cost <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ssd_disparity_stream.sv
// Directed bench for ssd_disparity_stream: pattern table per line, an expected-beat
// queue stamped with the input edge, and hand sequences for line_err and reset.
module tb_ssd_disparity_stream;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned WIDTH    = 64;
    localparam int unsigned WIN      = 5;
    localparam int unsigned DISP_MAX = 16;
    localparam int          BORDER_COLS = 19;

    logic        HCLK;
    logic        HRESETn;
    logic        in_valid, in_sol, in_sof;
    logic [7:0]  in_l, in_r;
    logic        out_valid, out_sof, out_sol, out_eol, out_border;
    logic [3:0]  out_disp;
    logic [18:0] out_cost;
    logic        line_err;

    ssd_disparity_stream #(
        .DATA_W   (DATA_W),
        .WIDTH    (WIDTH),
        .WIN      (WIN),
        .DISP_MAX (DISP_MAX)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .in_valid   (in_valid),
        .in_sol     (in_sol),
        .in_sof     (in_sof),
        .in_l       (in_l),
        .in_r       (in_r),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_border (out_border),
        .out_disp   (out_disp),
        .out_cost   (out_cost),
        .line_err   (line_err)
    );

    typedef struct {
        int          stamp;
        int          col;
        logic [26:0] exp;
    } exp_t;

    typedef struct {
        logic [7:0]  l_off;
        logic [7:0]  l_step;
        logic [7:0]  r_off;
        logic [7:0]  r_step;
        logic [3:0]  disp;
        logic [18:0] cost;
    } pat_t;

    exp_t q[$];
    exp_t m_e;
    pat_t pats[6];
    int   cyc = 0;
    int   col = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One valid beat; queues the expected result stamped with the sampling edge.
    task automatic send_px(input logic [7:0] l, input logic [7:0] r, input logic sol,
                           input logic sof, input logic [3:0] disp, input logic [18:0] cost);
        exp_t e;
        logic brd;
        if (sol || sof) col = 0;
        else if (col < WIDTH - 1) col++;
        brd     = (col < BORDER_COLS);
        e.stamp = cyc + 1;
        e.col   = col;
        e.exp   = {sof, sol | sof, col == WIDTH - 1, brd,
                   brd ? 4'd0 : disp, brd ? 19'd0 : cost};
        q.push_back(e);
        in_valid = 1'b1;
        in_l     = l;
        in_r     = r;
        in_sol   = sol;
        in_sof   = sof;
        @(posedge HCLK);
        #1;
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic send_line(input pat_t p, input int max_gap, input int last_x);
        for (int x = 0; x <= last_x; x++) begin
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
            send_px(8'(p.l_off + p.l_step * x), 8'(p.r_off + p.r_step * x),
                    x == 0, x == 0, p.disp, p.cost);
        end
    endtask

    // Every out_valid beat must match the oldest queued expectation, exactly 3 edges later.
    always @(posedge HCLK) begin
        #1;
        if (HRESETn && out_valid) begin
            if (q.size() == 0) begin
                check("spurious out_valid", 64'(out_valid), 64'd0);
            end else begin
                m_e = q.pop_front();
                check($sformatf("latency col%0d", m_e.col), 64'(cyc - m_e.stamp), 64'd3);
                check($sformatf("beat col%0d", m_e.col),
                      {37'd0, out_sof, out_sol, out_eol, out_border, out_disp, out_cost},
                      {37'd0, m_e.exp});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // l_off, l_step, r_off, r_step, expected disp, expected cost (hand-computed)
        pats[0] = '{8'd100, 8'd0, 8'd100, 8'd0, 4'd0,  19'd0};       // identical
        pats[1] = '{8'd0,   8'd1, 8'd3,   8'd1, 4'd3,  19'd0};       // R = L + 3
        pats[2] = '{8'd0,   8'd0, 8'd255, 8'd0, 4'd0,  19'd325125};  // all tie
        pats[3] = '{8'd2,   8'd1, 8'd0,   8'd1, 4'd0,  19'd20};      // diff d+2
        pats[4] = '{8'd0,   8'd1, 8'd20,  8'd1, 4'd15, 19'd125};     // beyond range
        pats[5] = '{8'd0,   8'd2, 8'd10,  8'd2, 4'd5,  19'd0};       // slope 2

        HRESETn  = 1'b0;
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_sof   = 1'b0;
        in_l     = '0;
        in_r     = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("reset outputs", {35'd0, out_valid, out_sof, out_sol, out_eol, out_border,
                                out_disp, out_cost, line_err}, 64'd0);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        for (int i = 0; i < 6; i++) begin
            send_line(pats[i], 0, WIDTH - 1);
            idle(3);
        end

        // Same ramp with random idle gaps.
        send_line(pats[1], 2, WIDTH - 1);
        idle(4);

        // 70 pixels in one line: overflow on the 65th.
        for (int i = 0; i < 70; i++) begin
            send_px(8'd100, 8'd100, i == 0, i == 0, 4'd0, 19'd0);
            if (i == 63) check("line_err after 64 px", 64'(line_err), 64'd0);
            if (i >= 64) check($sformatf("line_err after %0d px", i + 1), 64'(line_err), 64'd1);
        end
        in_sof = 1'b1;
        in_sol = 1'b1;
        @(posedge HCLK);
        #1;
        in_sof = 1'b0;
        in_sol = 1'b0;
        check("line_err kept by idle sof", 64'(line_err), 64'd1);
        send_px(8'd100, 8'd100, 1'b1, 1'b0, 4'd0, 19'd0);
        check("line_err kept by sol", 64'(line_err), 64'd1);
        send_px(8'd100, 8'd100, 1'b1, 1'b1, 4'd0, 19'd0);
        check("line_err cleared by sof", 64'(line_err), 64'd0);
        idle(5);

        // Reset asserted after column 30 is sampled; in-flight beats are dropped.
        send_line(pats[1], 0, 30);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mid-line reset outputs", {35'd0, out_valid, out_sof, out_sol, out_eol,
                                         out_border, out_disp, out_cost, line_err}, 64'd0);
        q.delete();
        col = 0;
        @(posedge HCLK);
        @(posedge HCLK);
        #3;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        send_line(pats[1], 0, WIDTH - 1);
        idle(6);

        check("expected beats still pending", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_disparity_stream.md
# ssd_disparity_stream

Streaming stereo-matching core that replaces the fixed two-pixel read/write path with a parametrised per-pixel disparity engine. It accepts one rectified left pixel and one right pixel per valid cycle, in raster order. For every left pixel it computes a 1-D horizontal-window sum-of-squared-differences cost over `DISP_MAX` candidate disparities, then emits the winning disparity and its cost. It sits between the stereo image reader and the depth-map image writer.

## Interface
- `DATA_W`, 8: pixel width, unsigned.
- `WIDTH`, 640: pixels per line.
- `WIN`, 5: horizontal window length in pixels, 1..15.
- `DISP_MAX`, 16: number of candidate disparities `d` = 0..DISP_MAX-1, 2..64.
- `HCLK` in 1: clock, rising edge.
- `HRESETn` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: pixel pair present this cycle.
- `in_sol` in 1: start of line; qualified by `in_valid`; marks column 0.
- `in_sof` in 1: start of frame; qualified by `in_valid`; implies `in_sol`.
- `in_l` in DATA_W: left pixel.
- `in_r` in DATA_W: right pixel.
- `out_valid` out 1: result present.
- `out_sof`, `out_sol`, `out_eol` out 1: delayed `in_sof` and `in_sol`, and a last-column flag.
- `out_border` out 1: window not fully inside the line; the result is forced.
- `out_disp` out clog2(DISP_MAX): winning disparity.
- `out_cost` out COST_W = 2*DATA_W+clog2(WIN+1): winning cost, unsigned.
- `line_err` out 1: sticky; more than `WIDTH` pixels were seen without `in_sol`; cleared by `in_sof`.

## Operation
- Column counter `x`:
  - Loads 0 on `in_valid & in_sol`; otherwise increments on `in_valid`.
  - Saturates at WIDTH-1. An increment attempted at WIDTH-1 sets `line_err`.
- History registers:
  - Left history: WIN entries. Right history: WIN+DISP_MAX-1 entries.
  - Both shift only on `in_valid`. Contents persist across idle cycles.
- Cost for column x: cost(d) = Σ_{k=0..WIN-1} (L[x-k] − R[x-k-d])². The window is trailing (causal).
- Differences are signed (DATA_W+1 bits) and are squared to 2*DATA_W bits. Sums are exact, with no saturation.
- Argmin: the smallest cost wins. On a tie, the smallest d wins.
- Border: when x < WIN+DISP_MAX-2, `out_border`=1, `out_disp`=0, `out_cost`=0. History from the previous line is never used.
- `out_eol`=1 on the result for x == WIDTH-1.
- Pipeline has three stages:
  - S1: per-(d,k) squared differences registered.
  - S2: per-d window sums registered.
  - S3: argmin registered to the outputs.
- Valid and sideband flags travel down the pipeline alongside the data. There is no backpressure: the downstream block must accept every `out_valid` beat.

## Timing
- Latency is exactly 3 cycles: an `in_valid` beat at edge t produces `out_valid` at edge t+3. Idle gaps are preserved one-for-one.
- Full throughput: one result per cycle while `in_valid` is held high.
- Reset, whenever asserted, including mid-line:
  - All outputs go to 0, `line_err`=0, `x`=0, and history clears to 0.
  - Pipeline valids clear, so in-flight results are dropped.
  - The first result after reset follows the first valid input by 3 cycles.
- `in_sol` mid-line restarts `x`=0 immediately. Results already in flight still emerge with their original flags.
- `in_sof` with `in_valid`=0 is ignored.

## Structure
- Package `ssd_pkg`:
  - Functions `cost_w(DATA_W,WIN)` and `disp_w(DISP_MAX)`.
  - Localparams for the border threshold.
  - Typedef for the cost vector.
- Sub-module `ssd_argmin`: a combinational linear compare over DISP_MAX costs with lowest-index tie-break, registered in the parent (S3).

## Test plan
Bench parameters: WIDTH=64, WIN=5, DISP_MAX=16, DATA_W=8.

- Identical images, L=R=constant 100 → non-border outputs: disp 0, cost 0. Columns 0..18 carry border=1. Latency measured as 3.
- Left L[x]=x, right R[x]=x+3 → from x≥19, disp 3 and cost 0 on every column; `out_eol` appears on column 63 only.
- Left L[x]=0, right R[x]=255 → disp 0 (tie-break), cost 5·255²=325125 (fits COST_W=19).
- Random `in_valid` gaps with the ramp pattern → output sequence identical to the gapless run, with `out_valid` gaps delayed by 3 cycles.
- 70 pixels without `in_sol` → `line_err`=1 after the 65th pixel; `x` holds at 63; the next `in_sof` clears the flag.
- `HRESETn` pulled low at column 30 → all outputs 0 within the same cycle. After release, a new line gives border=1 for columns 0..18.
